// File: rtl/timer_cnt_core_if.sv
// timer_cnt_core_if: control/status bundle between the
// APB register block (master) and the timer counting core (slave).
interface timer_cnt_core_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] tdr;
  logic             load;
  logic             dw;
  logic             en;
  logic [1:0]       clk_sel;
  logic             halt;
  logic [CNT_W-1:0] tcnt;
  logic             cnt_tick;
  logic             ovf_set;
  logic             udf_set;

  modport master (
    output tdr, load, dw, en, clk_sel, halt,
    input  tcnt, cnt_tick, ovf_set, udf_set
  );

  modport slave (
    input  tdr, load, dw, en, clk_sel, halt,
    output tcnt, cnt_tick, ovf_set, udf_set
  );
endinterface

// File: rtl/timer_cnt_core.sv
// timer_cnt_core: prescaler plus 8-bit up/down counter
// producing TCNT and single-cycle overflow/underflow pulses.
module timer_cnt_core #(
  parameter int CNT_W = 8,
  parameter int PRE_W = 4
) (
  input  logic              pclk,
  input  logic              presetn,
  timer_cnt_core_if.slave   bus
);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_tick;
  logic [CNT_W-1:0] r_tcnt;
  logic             r_ovf;
  logic             r_udf;

  logic [PRE_W:0]   w_mask_ext;
  logic [PRE_W-1:0] w_mask;
  logic             w_run;
  logic             w_tick_c;
  logic [CNT_W-1:0] w_tcnt_nxt;
  logic             w_ovf_nxt;
  logic             w_udf_nxt;

  // One extra bit so the /16 mask does not overflow before the -1.
  assign w_mask_ext = ((PRE_W+1)'(2) << bus.clk_sel)
                    - (PRE_W+1)'(1);
  assign w_mask     = w_mask_ext[PRE_W-1:0];
  assign w_run      = bus.en & ~bus.load;
  assign w_tick_c   = w_run & ~bus.halt
                    & ((r_pre_cnt & w_mask) == w_mask);

  // Prescaler: cleared when idle or loading, frozen by halt.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_pre_cnt <= '0;
    end else if (!w_run) begin
      r_pre_cnt <= '0;
    end else if (!bus.halt) begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  // Registered tick; held as-is through a halt.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tick <= 1'b0;
    end else if (!w_run) begin
      r_tick <= 1'b0;
    end else if (!bus.halt) begin
      r_tick <= w_tick_c;
    end
  end

  // Counter next value: load beats halt beats tick.
  always_comb begin
    w_tcnt_nxt = r_tcnt;
    w_ovf_nxt  = 1'b0;
    w_udf_nxt  = 1'b0;
    if (bus.load) begin
      w_tcnt_nxt = bus.tdr;
    end else if (!bus.halt && r_tick && bus.en) begin
      if (bus.dw) begin
        w_tcnt_nxt = r_tcnt - CNT_W'(1);
        w_udf_nxt  = (r_tcnt == '0);
      end else begin
        w_tcnt_nxt = r_tcnt + CNT_W'(1);
        w_ovf_nxt  = &r_tcnt;
      end
    end
  end

  // Counter and wrap-pulse registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tcnt <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_ovf  <= w_ovf_nxt;
      r_udf  <= w_udf_nxt;
    end
  end

  assign bus.tcnt     = r_tcnt;
  assign bus.cnt_tick = r_tick;
  assign bus.ovf_set  = r_ovf;
  assign bus.udf_set  = r_udf;

endmodule

// File: tb/tb_timer_cnt_core.sv
// tb_timer_cnt_core: scenario tasks with a queue of expected
// results pushed at stimulus time and popped at observation.
module tb_timer_cnt_core;

  logic pclk = 1'b0;
  logic presetn;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];

  always #5 pclk = ~pclk;

  timer_cnt_core_if #(.CNT_W(8)) bus ();

  timer_cnt_core #(.CNT_W(8), .PRE_W(4)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  // Observed outputs packed as {tcnt, tick, ovf, udf}.
  function automatic int obs();
    return {21'd0, bus.tcnt, bus.cnt_tick,
            bus.ovf_set, bus.udf_set};
  endfunction

  function automatic int mk(input logic [7:0] t,
                            input logic ti,
                            input logic o,
                            input logic u);
    return {21'd0, t, ti, o, u};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic idle();
    bus.tdr     = 8'h00;
    bus.load    = 1'b0;
    bus.dw      = 1'b0;
    bus.en      = 1'b0;
    bus.clk_sel = 2'b00;
    bus.halt    = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.en   = 1'b0;
    bus.tdr  = v;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic start(input logic d, input logic [1:0] s);
    bus.dw      = d;
    bus.clk_sel = s;
    bus.en      = 1'b1;
  endtask

  // Edges until cnt_tick seen high; -1 if the bound expires.
  task automatic wait_tick(input int limit, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < limit) begin
      step(1);
      i++;
      if (bus.cnt_tick === 1'b1) n = i;
    end
  endtask

  task automatic test_reset();
    int e, g;
    exp_q.push_back(mk(8'h00, 0, 0, 0));
    step(2);
    g = obs();
    e = exp_q.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL reset obs=%h exp=%h", g, e);
    end
  endtask

  task automatic test_up_overflow();
    int e, g;
    do_load(8'hFE);
    start(1'b0, 2'b00);
    exp_q.push_back(mk(8'hFE, 0, 0, 0));
    exp_q.push_back(mk(8'hFE, 1, 0, 0));
    exp_q.push_back(mk(8'hFF, 0, 0, 0));
    exp_q.push_back(mk(8'hFF, 1, 0, 0));
    exp_q.push_back(mk(8'h00, 0, 1, 0));
    exp_q.push_back(mk(8'h00, 1, 0, 0));
    for (int k = 1; k <= 6; k++) begin
      step(1);
      g = obs();
      e = exp_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL up_ovf edge%0d obs=%h exp=%h", k, g, e);
      end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_down_underflow();
    int e, g, pulses, tcnt_at, ticks, tick_prev;
    int ticks_at;
    do_load(8'hFF);
    start(1'b1, 2'b10);
    // 220th tick visible now; tcnt shows 219 ticks applied.
    exp_q.push_back(mk(8'h24, 1, 0, 0));
    step(220 * 8);
    g = obs();
    e = exp_q.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL dn_1760 obs=%h exp=%h", g, e);
    end
    ticks     = 220;
    tick_prev = 1;
    pulses    = 0;
    tcnt_at   = -1;
    ticks_at  = -1;
    exp_q.push_back(1);
    exp_q.push_back(32'hFF);
    exp_q.push_back(256);
    for (int k = 0; k < 320; k++) begin
      step(1);
      if (bus.udf_set === 1'b1) begin
        pulses++;
        tcnt_at  = int'(bus.tcnt);
        // pulse must follow the tick seen one edge earlier
        ticks_at = tick_prev ? ticks : -1;
      end
      if (bus.cnt_tick === 1'b1) ticks++;
      tick_prev = (bus.cnt_tick === 1'b1);
    end
    e = exp_q.pop_front();
    tests++;
    if (pulses !== e) begin
      fails++;
      $display("FAIL dn_pulses got=%0d exp=%0d", pulses, e);
    end
    e = exp_q.pop_front();
    tests++;
    if (tcnt_at !== e) begin
      fails++;
      $display("FAIL dn_wrap got=%h exp=%h", tcnt_at, e);
    end
    e = exp_q.pop_front();
    tests++;
    if (ticks_at !== e) begin
      fails++;
      $display("FAIL dn_tickno got=%0d exp=%0d", ticks_at, e);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_load_priority();
    int e, g;
    do_load(8'hFF);
    start(1'b0, 2'b00);
    exp_q.push_back(mk(8'hFF, 1, 0, 0));
    exp_q.push_back(mk(8'h55, 0, 0, 0));
    exp_q.push_back(mk(8'h55, 0, 0, 0));
    exp_q.push_back(mk(8'h55, 1, 0, 0));
    exp_q.push_back(mk(8'h56, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        bus.tdr  = 8'h55;
        bus.load = 1'b1;
      end
      if (k == 2) bus.load = 1'b0;
      step(k == 0 ? 2 : 1);
      g = obs();
      e = exp_q.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL ld_prio k%0d obs=%h exp=%h", k, g, e);
      end
    end
    bus.load = 1'b0;
    bus.en   = 1'b0;
  endtask

  task automatic test_enable_halt();
    int e, g, n, snap;
    do_load(8'h10);
    start(1'b0, 2'b11);
    exp_q.push_back(16);
    wait_tick(40, n);
    e = exp_q.pop_front();
    tests++;
    if (n !== e) begin
      fails++;
      $display("FAIL eh_first got=%0d exp=%0d", n, e);
    end
    step(2);
    bus.en = 1'b0;
    exp_q.push_back(mk(8'h11, 0, 0, 0));
    step(50);
    g = obs();
    e = exp_q.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL eh_en_off obs=%h exp=%h", g, e);
    end
    bus.en = 1'b1;
    exp_q.push_back(16);
    wait_tick(40, n);
    e = exp_q.pop_front();
    tests++;
    if (n !== e) begin
      fails++;
      $display("FAIL eh_reen got=%0d exp=%0d", n, e);
    end
    step(4);
    exp_q.push_back(mk(8'h12, 0, 0, 0));
    bus.halt = 1'b1;
    step(37);
    g = obs();
    e = exp_q.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL eh_halt obs=%h exp=%h", g, e);
    end
    snap = 12;
    bus.halt = 1'b0;
    exp_q.push_back(snap);
    wait_tick(80, n);
    e = exp_q.pop_front();
    tests++;
    if (n !== e) begin
      fails++;
      $display("FAIL eh_resume got=%0d exp=%0d", n, e);
    end
    exp_q.push_back(mk(8'h13, 0, 0, 0));
    step(1);
    g = obs();
    e = exp_q.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL eh_count obs=%h exp=%h", g, e);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_divider_sweep();
    int e, n;
    for (int s = 0; s < 4; s++) begin
      do_load(8'h00);
      start(1'b0, 2'(s));
      for (int k = 0; k < 10; k++) begin
        exp_q.push_back(2 << s);
        wait_tick(40, n);
        e = exp_q.pop_front();
        tests++;
        if (n !== e) begin
          fails++;
          $display("FAIL div sel%0d t%0d got=%0d exp=%0d",
                   s, k, n, e);
        end
      end
      bus.en = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    int e, g, seen;
    do_load(8'h80);
    start(1'b0, 2'b11);
    step(5);
    @(posedge pclk);
    #2;
    presetn = 1'b0;
    bus.en  = 1'b0;
    #1;
    exp_q.push_back(mk(8'h00, 0, 0, 0));
    g = obs();
    e = exp_q.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL rst_async obs=%h exp=%h", g, e);
    end
    step(2);
    presetn = 1'b1;
    exp_q.push_back(0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (bus.cnt_tick !== 1'b0) seen++;
    end
    e = exp_q.pop_front();
    tests++;
    if (seen !== e) begin
      fails++;
      $display("FAIL rst_noticks got=%0d exp=%0d", seen, e);
    end
    exp_q.push_back(mk(8'h00, 0, 0, 0));
    g = obs();
    e = exp_q.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL rst_after obs=%h exp=%h", g, e);
    end
  endtask

  initial begin
    presetn = 1'b0;
    idle();
    test_reset();
    presetn = 1'b1;
    step(1);
    test_up_overflow();
    test_down_underflow();
    test_load_priority();
    test_enable_halt();
    test_divider_sweep();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
